// File: rtl/nes_pkg.sv
// Shared definitions for the NES pad emulator and the host-side reader:
// FSM state encodings, button bit positions and the pad image helper.
package nes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int NUM_BITS = 8;

  // Serial bit order on the wire, bit 0 first.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // The pad line is active-low: a pressed button is sent as 0.
  function automatic logic [NUM_BITS-1:0] pad_image(input logic [NUM_BITS-1:0] pressed);
    return ~pressed;
  endfunction

endpackage

// File: rtl/nes_controller_emulator_sync_edge_det.sv
// Brings one asynchronous host pin into the clk domain and produces the
// synchronized level plus one-clk rise/fall strobes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain followed by one flop holding the previous level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // so the chain really delays by one clk per stage.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/nes_controller_emulator.sv
// Device-side NES game pad: answers the host's latch / nes_clk with the
// active-low serial button image, like the 4021 shift register in a real pad.
module nes_controller_emulator
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_latch_in,
  input  logic i_nes_clk_in,
  input  logic i_a,
  input  logic i_b,
  input  logic i_select,
  input  logic i_start,
  input  logic i_up,
  input  logic i_down,
  input  logic i_left,
  input  logic i_right,
  output logic o_data,
  output logic o_frame_done,
  output logic o_host_active
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     CNT_MAX = 4'(NUM_BITS);
  localparam logic [3:0]     CNT_END = 4'(NUM_BITS - 2);

  logic                w_latch_level, w_latch_rise, w_latch_fall;
  logic                w_nclk_level, w_nclk_rise, w_nclk_fall;
  logic                w_unused_ok;
  logic [NUM_BITS-1:0] w_buttons, w_image;
  logic                w_timeout;

  state_t              r_state, w_state_nxt;
  logic [NUM_BITS-1:0] r_shift_reg, w_shift_nxt;
  logic [3:0]          r_bit_cnt, w_cnt_nxt;
  logic                r_frame_done, w_fd_nxt;
  logic                r_host_active;
  logic [TW-1:0]       r_to_cnt;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_latch_in),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_nclk_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_nes_clk_in),
    .o_level (w_nclk_level),
    .o_rise  (w_nclk_rise),
    .o_fall  (w_nclk_fall)
  );

  // Only the nes_clk rise matters; its level and fall are deliberately dropped.
  assign w_unused_ok = &{1'b0, w_nclk_level, w_nclk_fall};

  assign w_buttons[BTN_A]      = i_a;
  assign w_buttons[BTN_B]      = i_b;
  assign w_buttons[BTN_SELECT] = i_select;
  assign w_buttons[BTN_START]  = i_start;
  assign w_buttons[BTN_UP]     = i_up;
  assign w_buttons[BTN_DOWN]   = i_down;
  assign w_buttons[BTN_LEFT]   = i_left;
  assign w_buttons[BTN_RIGHT]  = i_right;
  assign w_image               = pad_image(w_buttons);

  assign w_timeout = (r_to_cnt == TO_MAX);

  // Next-state, shift register and frame_done; a latch rise beats everything.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_state_nxt = r_state;
    w_shift_nxt = r_shift_reg;
    w_cnt_nxt   = r_bit_cnt;
    w_fd_nxt    = 1'b0;
    if (w_latch_rise) begin
      w_state_nxt = LOAD;
      w_shift_nxt = w_image;
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '1;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          if (w_latch_fall) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
          end else if (w_latch_level) begin
            w_shift_nxt = w_image;
          end
        end
        SHIFT: begin
          if (w_nclk_rise) begin
            w_shift_nxt = {1'b1, r_shift_reg[NUM_BITS-1:1]};
            if (r_bit_cnt != CNT_MAX) w_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == CNT_END) w_fd_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_shift_nxt = '1;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and datapath registers; data is taken straight from shift_reg[0].
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_shift_reg  <= '1;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift_reg  <= w_shift_nxt;
      r_bit_cnt    <= w_cnt_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  // Host-presence watchdog: cleared by each latch rise, saturates at the limit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_to_cnt      <= '0;
      r_host_active <= 1'b0;
    end else if (w_latch_rise) begin
      r_to_cnt      <= '0;
      r_host_active <= 1'b1;
    end else begin
      if (!w_timeout) r_to_cnt <= r_to_cnt + TW'(1);
      if (w_timeout)  r_host_active <= 1'b0;
    end
  end

  assign o_data        = r_shift_reg[0];
  assign o_frame_done  = r_frame_done;
  assign o_host_active = r_host_active;

endmodule
